// File: rtl/cpu_pkg.sv
// Shared constants for the 5-stage 16-bit CPU datapath.
//  DW        datapath width (PC, instruction, operands, immediates, ALU result)
//  RW        register-specifier width
//  CTRL2_W   width of bsrc / reg_src / branch_ctrl selects
//  CTRL3_W   width of alu_ctrl / set_ctrl opcodes
//  NOP_INSTR ISA NOP (opcode 00001), held in IF/ID after reset
package cpu_pkg;
  localparam int unsigned DW      = 16;
  localparam int unsigned RW      = 3;
  localparam int unsigned CTRL2_W = 2;
  localparam int unsigned CTRL3_W = 3;
  localparam logic [15:0] NOP_INSTR = 16'h0800;
endpackage

// File: rtl/pipeline_latches_pipe_reg.sv
// pipe_reg: W-bit D flop with synchronous active-high reset to RST_VAL.
//  clk  in   rising-edge clock
//  rst  in   synchronous reset, loads RST_VAL
//  d    in   W-bit next value
//  q    out  W-bit registered value
module pipe_reg #(
  parameter int unsigned    W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= RST_VAL;
    else     q <= d;
  end

endmodule

// File: rtl/pipeline_latches.sv
// pipeline_latches: IF/ID, ID/EX and EX/MEM forward pipeline registers.
// Every *_in is captured on the rising edge and presented on the matching
// *_out for one cycle. Reset clears everything except the IF/ID instruction,
// which reloads the ISA NOP. No enable/stall/flush: all stages load each cycle.
//  clk, rst          clock, synchronous active-high reset
//  ifid_*            PC+2, instruction, un-incremented PC
//  idex_*            operands, immediates, control selects/opcodes, dest reg, control bits
//  exmem_*           ALU result, B operand, offsets, store data, PC+2, imm, control
module pipeline_latches
  import cpu_pkg::*;
#(
  parameter int unsigned   DW        = cpu_pkg::DW,
  parameter int unsigned   RW        = cpu_pkg::RW,
  parameter logic [DW-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst,
  // IF/ID
  input  logic [DW-1:0]       ifid_pc_next_in,
  input  logic [DW-1:0]       ifid_instruction_in,
  input  logic [DW-1:0]       ifid_pc_no_plus_two_in,
  output logic [DW-1:0]       ifid_pc_next_out,
  output logic [DW-1:0]       ifid_instruction_out,
  output logic [DW-1:0]       ifid_pc_no_plus_two_out,
  // ID/EX
  input  logic [DW-1:0]       idex_read_data1_in,
  input  logic [DW-1:0]       idex_read_data2_in,
  input  logic [DW-1:0]       idex_four_ext_in,
  input  logic [DW-1:0]       idex_seven_ext_in,
  input  logic [DW-1:0]       idex_shifted_in,
  input  logic [DW-1:0]       idex_word_align_jump_in,
  input  logic [DW-1:0]       idex_pc2_in,
  input  logic [1:0]          idex_bsrc_in,
  input  logic [1:0]          idex_branch_ctrl_in,
  input  logic [1:0]          idex_reg_src_in,
  input  logic [2:0]          idex_alu_ctrl_in,
  input  logic [2:0]          idex_set_ctrl_in,
  input  logic [RW-1:0]       idex_write_reg_in,
  input  logic                idex_inv_a_in,
  input  logic                idex_inv_b_in,
  input  logic                idex_branch_in,
  input  logic                idex_slbi_in,
  input  logic                idex_btr_in,
  input  logic                idex_mem_wrt_in,
  input  logic                idex_alu_jmp_in,
  input  logic                idex_pc_or_add_in,
  input  logic                idex_halt_in,
  input  logic                idex_reg_wrt_in,
  input  logic                idex_send_nop_in,
  output logic [DW-1:0]       idex_read_data1_out,
  output logic [DW-1:0]       idex_read_data2_out,
  output logic [DW-1:0]       idex_four_ext_out,
  output logic [DW-1:0]       idex_seven_ext_out,
  output logic [DW-1:0]       idex_shifted_out,
  output logic [DW-1:0]       idex_word_align_jump_out,
  output logic [DW-1:0]       idex_pc2_out,
  output logic [1:0]          idex_bsrc_out,
  output logic [1:0]          idex_branch_ctrl_out,
  output logic [1:0]          idex_reg_src_out,
  output logic [2:0]          idex_alu_ctrl_out,
  output logic [2:0]          idex_set_ctrl_out,
  output logic [RW-1:0]       idex_write_reg_out,
  output logic                idex_inv_a_out,
  output logic                idex_inv_b_out,
  output logic                idex_branch_out,
  output logic                idex_slbi_out,
  output logic                idex_btr_out,
  output logic                idex_mem_wrt_out,
  output logic                idex_alu_jmp_out,
  output logic                idex_pc_or_add_out,
  output logic                idex_halt_out,
  output logic                idex_reg_wrt_out,
  output logic                idex_send_nop_out,
  // EX/MEM
  input  logic [DW-1:0]       exmem_alu_in,
  input  logic [DW-1:0]       exmem_b_input_in,
  input  logic [DW-1:0]       exmem_sgn_ext_in,
  input  logic [DW-1:0]       exmem_read_data2_in,
  input  logic [DW-1:0]       exmem_pc2_in,
  input  logic [DW-1:0]       exmem_seven_ext_in,
  input  logic [1:0]          exmem_reg_src_in,
  input  logic [RW-1:0]       exmem_write_reg_in,
  input  logic                exmem_branch_take_in,
  input  logic                exmem_branch_in,
  input  logic                exmem_pc_or_add_in,
  input  logic                exmem_alu_jmp_in,
  input  logic                exmem_mem_wrt_in,
  input  logic                exmem_halt_in,
  input  logic                exmem_reg_wrt_in,
  input  logic                exmem_send_nop_in,
  output logic [DW-1:0]       exmem_alu_out,
  output logic [DW-1:0]       exmem_b_input_out,
  output logic [DW-1:0]       exmem_sgn_ext_out,
  output logic [DW-1:0]       exmem_read_data2_out,
  output logic [DW-1:0]       exmem_pc2_out,
  output logic [DW-1:0]       exmem_seven_ext_out,
  output logic [1:0]          exmem_reg_src_out,
  output logic [RW-1:0]       exmem_write_reg_out,
  output logic                exmem_branch_take_out,
  output logic                exmem_branch_out,
  output logic                exmem_pc_or_add_out,
  output logic                exmem_alu_jmp_out,
  output logic                exmem_mem_wrt_out,
  output logic                exmem_halt_out,
  output logic                exmem_reg_wrt_out,
  output logic                exmem_send_nop_out
);

  // ---------------- IF/ID ----------------
  // Only the instruction register has a non-zero reset value.
  pipe_reg #(.W(DW), .RST_VAL('0)) u_ifid_pc_next (
    .clk(clk), .rst(rst), .d(ifid_pc_next_in), .q(ifid_pc_next_out));
  pipe_reg #(.W(DW), .RST_VAL(NOP_INSTR)) u_ifid_instr (
    .clk(clk), .rst(rst), .d(ifid_instruction_in), .q(ifid_instruction_out));
  pipe_reg #(.W(DW), .RST_VAL('0)) u_ifid_pc (
    .clk(clk), .rst(rst), .d(ifid_pc_no_plus_two_in), .q(ifid_pc_no_plus_two_out));

  // ---------------- ID/EX ----------------
  localparam int unsigned IDEX_W = 7*DW + 3*CTRL2_W + 2*CTRL3_W + RW + 11;
  logic [IDEX_W-1:0] idex_d, idex_q;

  assign idex_d = {idex_read_data1_in, idex_read_data2_in, idex_four_ext_in,
                   idex_seven_ext_in, idex_shifted_in, idex_word_align_jump_in,
                   idex_pc2_in, idex_bsrc_in, idex_branch_ctrl_in, idex_reg_src_in,
                   idex_alu_ctrl_in, idex_set_ctrl_in, idex_write_reg_in,
                   idex_inv_a_in, idex_inv_b_in, idex_branch_in, idex_slbi_in,
                   idex_btr_in, idex_mem_wrt_in, idex_alu_jmp_in, idex_pc_or_add_in,
                   idex_halt_in, idex_reg_wrt_in, idex_send_nop_in};

  pipe_reg #(.W(IDEX_W), .RST_VAL('0)) u_idex (
    .clk(clk), .rst(rst), .d(idex_d), .q(idex_q));

  assign {idex_read_data1_out, idex_read_data2_out, idex_four_ext_out,
          idex_seven_ext_out, idex_shifted_out, idex_word_align_jump_out,
          idex_pc2_out, idex_bsrc_out, idex_branch_ctrl_out, idex_reg_src_out,
          idex_alu_ctrl_out, idex_set_ctrl_out, idex_write_reg_out,
          idex_inv_a_out, idex_inv_b_out, idex_branch_out, idex_slbi_out,
          idex_btr_out, idex_mem_wrt_out, idex_alu_jmp_out, idex_pc_or_add_out,
          idex_halt_out, idex_reg_wrt_out, idex_send_nop_out} = idex_q;

  // ---------------- EX/MEM ----------------
  localparam int unsigned EXMEM_W = 6*DW + CTRL2_W + RW + 8;
  logic [EXMEM_W-1:0] exmem_d, exmem_q;

  assign exmem_d = {exmem_alu_in, exmem_b_input_in, exmem_sgn_ext_in,
                    exmem_read_data2_in, exmem_pc2_in, exmem_seven_ext_in,
                    exmem_reg_src_in, exmem_write_reg_in, exmem_branch_take_in,
                    exmem_branch_in, exmem_pc_or_add_in, exmem_alu_jmp_in,
                    exmem_mem_wrt_in, exmem_halt_in, exmem_reg_wrt_in,
                    exmem_send_nop_in};

  pipe_reg #(.W(EXMEM_W), .RST_VAL('0)) u_exmem (
    .clk(clk), .rst(rst), .d(exmem_d), .q(exmem_q));

  assign {exmem_alu_out, exmem_b_input_out, exmem_sgn_ext_out,
          exmem_read_data2_out, exmem_pc2_out, exmem_seven_ext_out,
          exmem_reg_src_out, exmem_write_reg_out, exmem_branch_take_out,
          exmem_branch_out, exmem_pc_or_add_out, exmem_alu_jmp_out,
          exmem_mem_wrt_out, exmem_halt_out, exmem_reg_wrt_out,
          exmem_send_nop_out} = exmem_q;

endmodule

// File: tb/tb_pipeline_latches.sv
// Self-checking bench for pipeline_latches: table of vectors plus hand
// sequences, expected stage contents queued at drive time and popped after
// the capturing edge.
module tb_pipeline_latches;

  typedef struct packed {
    logic [15:0] pc_next, instruction, pc_no_plus_two;
  } ifid_t;

  typedef struct packed {
    logic [15:0] read_data1, read_data2, four_ext, seven_ext, shifted, word_align_jump, pc2;
    logic [1:0]  bsrc, branch_ctrl, reg_src;
    logic [2:0]  alu_ctrl, set_ctrl, write_reg;
    logic inv_a, inv_b, branch, slbi, btr, mem_wrt, alu_jmp, pc_or_add, halt, reg_wrt, send_nop;
  } idex_t;

  typedef struct packed {
    logic [15:0] alu, b_input, sgn_ext, read_data2, pc2, seven_ext;
    logic [1:0]  reg_src;
    logic [2:0]  write_reg;
    logic branch_take, branch, pc_or_add, alu_jmp, mem_wrt, halt, reg_wrt, send_nop;
  } exmem_t;

  typedef struct packed {
    ifid_t  ifid;
    idex_t  idex;
    exmem_t exmem;
  } all_t;

  typedef struct {
    string name;
    logic  rst;
    all_t  in;
    all_t  exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  all_t din;
  all_t dout;

  always #5 clk = ~clk;

  pipeline_latches #(.DW(16), .RW(3), .NOP_INSTR(16'h0800)) dut (
    .clk(clk), .rst(rst),
    .ifid_pc_next_in(din.ifid.pc_next),
    .ifid_instruction_in(din.ifid.instruction),
    .ifid_pc_no_plus_two_in(din.ifid.pc_no_plus_two),
    .ifid_pc_next_out(dout.ifid.pc_next),
    .ifid_instruction_out(dout.ifid.instruction),
    .ifid_pc_no_plus_two_out(dout.ifid.pc_no_plus_two),
    .idex_read_data1_in(din.idex.read_data1),
    .idex_read_data2_in(din.idex.read_data2),
    .idex_four_ext_in(din.idex.four_ext),
    .idex_seven_ext_in(din.idex.seven_ext),
    .idex_shifted_in(din.idex.shifted),
    .idex_word_align_jump_in(din.idex.word_align_jump),
    .idex_pc2_in(din.idex.pc2),
    .idex_bsrc_in(din.idex.bsrc),
    .idex_branch_ctrl_in(din.idex.branch_ctrl),
    .idex_reg_src_in(din.idex.reg_src),
    .idex_alu_ctrl_in(din.idex.alu_ctrl),
    .idex_set_ctrl_in(din.idex.set_ctrl),
    .idex_write_reg_in(din.idex.write_reg),
    .idex_inv_a_in(din.idex.inv_a),
    .idex_inv_b_in(din.idex.inv_b),
    .idex_branch_in(din.idex.branch),
    .idex_slbi_in(din.idex.slbi),
    .idex_btr_in(din.idex.btr),
    .idex_mem_wrt_in(din.idex.mem_wrt),
    .idex_alu_jmp_in(din.idex.alu_jmp),
    .idex_pc_or_add_in(din.idex.pc_or_add),
    .idex_halt_in(din.idex.halt),
    .idex_reg_wrt_in(din.idex.reg_wrt),
    .idex_send_nop_in(din.idex.send_nop),
    .idex_read_data1_out(dout.idex.read_data1),
    .idex_read_data2_out(dout.idex.read_data2),
    .idex_four_ext_out(dout.idex.four_ext),
    .idex_seven_ext_out(dout.idex.seven_ext),
    .idex_shifted_out(dout.idex.shifted),
    .idex_word_align_jump_out(dout.idex.word_align_jump),
    .idex_pc2_out(dout.idex.pc2),
    .idex_bsrc_out(dout.idex.bsrc),
    .idex_branch_ctrl_out(dout.idex.branch_ctrl),
    .idex_reg_src_out(dout.idex.reg_src),
    .idex_alu_ctrl_out(dout.idex.alu_ctrl),
    .idex_set_ctrl_out(dout.idex.set_ctrl),
    .idex_write_reg_out(dout.idex.write_reg),
    .idex_inv_a_out(dout.idex.inv_a),
    .idex_inv_b_out(dout.idex.inv_b),
    .idex_branch_out(dout.idex.branch),
    .idex_slbi_out(dout.idex.slbi),
    .idex_btr_out(dout.idex.btr),
    .idex_mem_wrt_out(dout.idex.mem_wrt),
    .idex_alu_jmp_out(dout.idex.alu_jmp),
    .idex_pc_or_add_out(dout.idex.pc_or_add),
    .idex_halt_out(dout.idex.halt),
    .idex_reg_wrt_out(dout.idex.reg_wrt),
    .idex_send_nop_out(dout.idex.send_nop),
    .exmem_alu_in(din.exmem.alu),
    .exmem_b_input_in(din.exmem.b_input),
    .exmem_sgn_ext_in(din.exmem.sgn_ext),
    .exmem_read_data2_in(din.exmem.read_data2),
    .exmem_pc2_in(din.exmem.pc2),
    .exmem_seven_ext_in(din.exmem.seven_ext),
    .exmem_reg_src_in(din.exmem.reg_src),
    .exmem_write_reg_in(din.exmem.write_reg),
    .exmem_branch_take_in(din.exmem.branch_take),
    .exmem_branch_in(din.exmem.branch),
    .exmem_pc_or_add_in(din.exmem.pc_or_add),
    .exmem_alu_jmp_in(din.exmem.alu_jmp),
    .exmem_mem_wrt_in(din.exmem.mem_wrt),
    .exmem_halt_in(din.exmem.halt),
    .exmem_reg_wrt_in(din.exmem.reg_wrt),
    .exmem_send_nop_in(din.exmem.send_nop),
    .exmem_alu_out(dout.exmem.alu),
    .exmem_b_input_out(dout.exmem.b_input),
    .exmem_sgn_ext_out(dout.exmem.sgn_ext),
    .exmem_read_data2_out(dout.exmem.read_data2),
    .exmem_pc2_out(dout.exmem.pc2),
    .exmem_seven_ext_out(dout.exmem.seven_ext),
    .exmem_reg_src_out(dout.exmem.reg_src),
    .exmem_write_reg_out(dout.exmem.write_reg),
    .exmem_branch_take_out(dout.exmem.branch_take),
    .exmem_branch_out(dout.exmem.branch),
    .exmem_pc_or_add_out(dout.exmem.pc_or_add),
    .exmem_alu_jmp_out(dout.exmem.alu_jmp),
    .exmem_mem_wrt_out(dout.exmem.mem_wrt),
    .exmem_halt_out(dout.exmem.halt),
    .exmem_reg_wrt_out(dout.exmem.reg_wrt),
    .exmem_send_nop_out(dout.exmem.send_nop)
  );

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;
  all_t        sb[$];
  all_t        last_exp;
  bit          have_last = 1'b0;
  all_t        reset_val;
  vec_t        tbl[$];

  function automatic all_t rand_all();
    logic [$bits(all_t)-1:0] b;
    for (int i = 0; i < $bits(all_t); i++) b[i] = 1'($urandom_range(0, 1));
    return all_t'(b);
  endfunction

  task automatic cmp(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input all_t act, input all_t exp);
    cmp({name, ".ifid"},  512'(act.ifid),  512'(exp.ifid));
    cmp({name, ".idex"},  512'(act.idex),  512'(exp.idex));
    cmp({name, ".exmem"}, 512'(act.exmem), 512'(exp.exmem));
  endtask

  // Drive one cycle. Before the edge the outputs must still hold the previous
  // result (no in->out path); after the edge they must match the popped entry.
  task automatic step(input string name, input logic r, input all_t v, input all_t e);
    all_t got;
    rst = r;
    din = v;
    sb.push_back(e);
    #2;
    if (have_last) check_all({name, ".hold"}, dout, last_exp);
    @(posedge clk);
    #1;
    n_vec++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL %s.sb: got empty queue want 1 entry", name);
    end else begin
      n_vec--;
      got = sb.pop_front();
      check_all(name, dout, got);
    end
    last_exp  = e;
    have_last = 1'b1;
  endtask

  task automatic add(input string name, input logic r, input all_t v);
    vec_t t;
    t.name = name;
    t.rst  = r;
    t.in   = v;
    t.exp  = r ? reset_val : v;
    tbl.push_back(t);
  endtask

  initial begin
    all_t v;
    all_t e;
    reset_val = '0;
    reset_val.ifid.instruction = 16'h0800;

    // ---- table fill ----
    add("reset", 1'b1, rand_all());

    v = '0;
    v.ifid.instruction = 16'hC123;
    v.ifid.pc_next     = 16'h0002;
    add("ifid_pass", 1'b0, v);

    v = '0; v.idex = '1;
    add("idex_ones", 1'b0, v);
    v = '0;
    add("idex_zeros", 1'b0, v);
    for (int unsigned i = 0; i < 16; i++) begin
      v = '0;
      v.idex.read_data1 = 16'(1) << i;
      add($sformatf("idex_walk%0d", i), 1'b0, v);
    end

    v = '0;
    v.exmem.branch_take = 1'b1;
    v.exmem.halt        = 1'b1;
    v.exmem.write_reg   = 3'b101;
    v.exmem.alu         = 16'hFFFE;
    for (int unsigned i = 0; i < 3; i++) add($sformatf("exmem_ctrl%0d", i), 1'b0, v);

    // ---- table apply ----
    rst = 1'b0;
    din = '0;
    @(posedge clk);
    #1;
    for (int unsigned i = 0; i < tbl.size(); i++)
      step(tbl[i].name, tbl[i].rst, tbl[i].in, tbl[i].exp);

    // ---- mid-stream reset ----
    for (int unsigned i = 0; i < 5; i++) begin
      v = rand_all();
      step($sformatf("stream%0d", i), 1'b0, v, v);
    end
    step("mid_reset", 1'b1, rand_all(), reset_val);
    v = rand_all();
    step("resume", 1'b0, v, v);

    // ---- chaining ID/EX -> EX/MEM ----
    v = '0;
    v.idex.pc2 = 16'h0010;
    step("chain1", 1'b0, v, v);
    v = '0;
    v.exmem.pc2 = dout.idex.pc2;
    e = '0;
    e.exmem.pc2 = 16'h0010;
    step("chain2", 1'b0, v, e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
